kf_frame_sequencer: RTL

// Frame initiator for the 2x2 Kalman filter core: buffers per-frame measurement/input samples from an upstream valid/ready stream.

---
 rtl/kf_frame_sequencer_if.sv | 49 ++++
 rtl/kf_frame_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/kf_frame_sequencer_if.sv
// Stream and core-side bundle for the Kalman frame sequencer.
// master is the sequencer's view; slave is the environment's view.
interface kf_frame_sequencer_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_z00;
  logic [N-1:0] in_z10;
  logic [N-1:0] in_u00;
  logic [N-1:0] in_u10;

  logic         kf_start;
  logic [N-1:0] kf_z00;
  logic [N-1:0] kf_z10;
  logic [N-1:0] kf_u00;
  logic [N-1:0] kf_u10;
  logic [N-1:0] kf_x00_prev;
  logic [N-1:0] kf_x10_prev;
  logic         kf_done;
  logic [N-1:0] kf_x00_post;
  logic [N-1:0] kf_x10_post;

  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_x00;
  logic [N-1:0] out_x10;
  logic [15:0]  out_idx;

  modport master (
    input  in_valid, in_z00, in_z10, in_u00, in_u10,
    output in_ready,
    output kf_start, kf_z00, kf_z10, kf_u00, kf_u10,
    output kf_x00_prev, kf_x10_prev,
    input  kf_done, kf_x00_post, kf_x10_post,
    output out_valid, out_x00, out_x10, out_idx,
    input  out_ready
  );

  modport slave (
    output in_valid, in_z00, in_z10, in_u00, in_u10,
    input  in_ready,
    input  kf_start, kf_z00, kf_z10, kf_u00, kf_u10,
    input  kf_x00_prev, kf_x10_prev,
    output kf_done, kf_x00_post, kf_x10_post,
    input  out_valid, out_x00, out_x10, out_idx,
    output out_ready
  );
endinterface

// File: rtl/kf_frame_sequencer.sv
// Frame sequencer for the 2x2 Kalman core: sample FIFO, start/done FSM, state feedback.
// Optional watchdog on the core's done pulse: define KFSEQ_WDOG_EN.
`ifndef FXP_N
`define FXP_N 16
`endif
`ifndef FXP_FRAC
`define FXP_FRAC 8
`endif

module kf_frame_sequencer #(
  parameter int           N       = `FXP_N,
  parameter int           FRAC    = `FXP_FRAC,
  parameter int           DEPTH   = 4,
  parameter int           TIMEOUT = 40,
  parameter logic [N-1:0] X0_00   = '0,
  parameter logic [N-1:0] X0_10   = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    init,
  kf_frame_sequencer_if.master    bus,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    err_timeout
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and >= 2");
  end
  if (FRAC < 0 || FRAC >= N || TIMEOUT < 2 || TIMEOUT > 64) begin : g_bad_cfg
    $error("FRAC or TIMEOUT out of range");
  end

  typedef struct packed {
    logic [N-1:0] z00;
    logic [N-1:0] z10;
    logic [N-1:0] u00;
    logic [N-1:0] u10;
  } sample_t;

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

  state_t        state, state_nx;
  sample_t       mem [DEPTH];
  sample_t       op;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic [N-1:0]  x00_prev, x10_prev;
  logic [N-1:0]  x00_out, x10_out;
  logic [15:0]   frame_idx, idx_out;
  logic          valid_out, rdy;
  logic          push, pop, can_go;
  logic          do_init, done_ok, wdog_hit;

  assign rdy    = level < FULL;
  assign push   = bus.in_valid && rdy;
  assign can_go = (level != '0) && (!valid_out || bus.out_ready);

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    do_init  = 1'b0;
    done_ok  = 1'b0;
    unique case (state)
      IDLE: begin
        if (init) begin
          do_init = 1'b1;
        end else if (can_go) begin
          state_nx = START;
          pop      = 1'b1;
        end
      end
      START: state_nx = WAIT;
      WAIT: begin
        if (bus.kf_done) begin
          done_ok  = 1'b1;
          state_nx = GAP;
        end else if (wdog_hit) begin
          state_nx = IDLE;
        end
      end
      GAP: begin
        // core drops its run flag here, so relaunch waits one cycle
        if (can_go) begin
          state_nx = START;
          pop      = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{bus.in_z00, bus.in_z10, bus.in_u00, bus.in_u10};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case (1'b1)
        push && !pop: level <= level + (AW+1)'(1);
        pop && !push: level <= level - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   op <= '0;
    else if (pop) op <= mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x00_prev  <= X0_00;
      x10_prev  <= X0_10;
      x00_out   <= '0;
      x10_out   <= '0;
      idx_out   <= '0;
      frame_idx <= '0;
      valid_out <= 1'b0;
    end else begin
      if (do_init) begin
        x00_prev  <= X0_00;
        x10_prev  <= X0_10;
        frame_idx <= '0;
      end
      if (done_ok) begin
        x00_prev  <= bus.kf_x00_post;
        x10_prev  <= bus.kf_x10_post;
        x00_out   <= bus.kf_x00_post;
        x10_out   <= bus.kf_x10_post;
        idx_out   <= frame_idx;
        frame_idx <= frame_idx + 16'd1;
      end
      if (done_ok)                         valid_out <= 1'b1;
      else if (valid_out && bus.out_ready) valid_out <= 1'b0;
    end
  end

`ifdef KFSEQ_WDOG_EN
  logic [5:0] wdog_cnt;

  // counts from the START cycle; a done in the last cycle still wins
  assign wdog_hit = (state == WAIT) && !bus.kf_done &&
                    (wdog_cnt == 6'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            wdog_cnt <= '0;
    else if (state == IDLE || state == GAP) wdog_cnt <= '0;
    else                                   wdog_cnt <= wdog_cnt + 6'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        err_timeout <= 1'b0;
    else if (wdog_hit) err_timeout <= 1'b1;
  end
`else
  assign wdog_hit    = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign bus.in_ready    = rdy;
  assign bus.kf_start    = (state == START);
  assign bus.kf_z00      = op.z00;
  assign bus.kf_z10      = op.z10;
  assign bus.kf_u00      = op.u00;
  assign bus.kf_u10      = op.u10;
  assign bus.kf_x00_prev = x00_prev;
  assign bus.kf_x10_prev = x10_prev;
  assign bus.out_valid   = valid_out;
  assign bus.out_x00     = x00_out;
  assign bus.out_x10     = x10_out;
  assign bus.out_idx     = idx_out;
  assign busy            = (state != IDLE);
  assign fifo_level      = level;

endmodule
